mr_rf_scoreboard: RTL and testbench

Parametrised integer register file with a per-register write-pending scoreboard, split out of the decode stage so decode can scale to more read ports and deeper pipelines. It sits between instruction decode (read ports, issue reservations) and writeback (register writes). It provides operand data, per-port RAW hazard flags, optional same-cycle writeback bypass, saturation back-pressure and sticky error detection.

---
 rtl/mr_rf_scoreboard.sv | 111 +++++++++++
 tb/tb_mr_rf_scoreboard.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mr_rf_scoreboard.sv
// Integer register file with a per-register pending-write scoreboard.
// Feeds decode with operands and RAW hazard flags and takes writeback results.
module mr_rf_scoreboard #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int RD_PORTS  = 2,
    parameter int PEND_BITS = 2,
    parameter int BYPASS    = 1,
    localparam int RSEL     = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RD_PORTS*RSEL-1:0] rd_sel,
    input  logic [RD_PORTS-1:0]      rd_use,
    output logic [RD_PORTS*XLEN-1:0] rd_data,
    output logic [RD_PORTS-1:0]      rd_hazard,
    output logic                     hazard,
    input  logic                     issue_valid,
    input  logic [RSEL-1:0]          issue_dst,
    output logic                     issue_ready,
    input  logic                     wb_valid,
    input  logic [RSEL-1:0]          wb_reg,
    input  logic [XLEN-1:0]          wb_val,
    output logic                     busy,
    output logic                     err
);

    localparam logic [PEND_BITS-1:0] PEND_MAX = '1;

    logic [XLEN-1:0]      regs [1:NREGS-1];
    logic [PEND_BITS-1:0] pend [1:NREGS-1];
    logic                 fire;
    logic                 wb_live;
    logic                 underflow;
    logic                 sat_fire;

    // Reg 0 has no storage; these accessors return zero for it.
    function automatic logic [PEND_BITS-1:0] pend_of(input logic [RSEL-1:0] r);
        return (r == '0) ? '0 : pend[r];
    endfunction

    function automatic logic [XLEN-1:0] reg_of(input logic [RSEL-1:0] r);
        return (r == '0) ? '0 : regs[r];
    endfunction

    assign wb_live     = wb_valid && (wb_reg != '0);
    assign issue_ready = !rst && ((issue_dst == '0) || (pend_of(issue_dst) != PEND_MAX));
    assign fire        = issue_valid && issue_ready;
    assign underflow   = wb_live && (pend_of(wb_reg) == '0) && !(fire && (issue_dst == wb_reg));
    assign sat_fire    = fire && (issue_dst != '0) && (pend_of(issue_dst) == PEND_MAX);

    always_comb begin
        logic [RSEL-1:0]      sel;
        logic [PEND_BITS-1:0] pcnt;
        logic                 fwd;
        sel       = '0;
        pcnt      = '0;
        fwd       = 1'b0;
        rd_data   = '0;
        rd_hazard = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            sel  = rd_sel[p*RSEL +: RSEL];
            fwd  = (BYPASS != 0) && wb_valid && (wb_reg == sel);
            pcnt = pend_of(sel);
            // A same-cycle writeback retires one outstanding write when forwarding.
            if (fwd && (pcnt != '0)) begin
                pcnt = pcnt - 1'b1;
            end
            if (sel != '0) begin
                rd_data[p*XLEN +: XLEN] = fwd ? wb_val : reg_of(sel);
                rd_hazard[p]            = (pcnt != '0);
            end
        end
    end

    assign hazard = |(rd_use & rd_hazard);

    always_comb begin
        busy = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            busy = busy | (pend[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < NREGS; r++) begin
                regs[r] <= '0;
                pend[r] <= '0;
            end
            err <= 1'b0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (wb_live && (wb_reg == RSEL'(r))) begin
                    regs[r] <= wb_val;
                end
                // Simultaneous reservation and retirement cancel out.
                case ({fire && (issue_dst == RSEL'(r)),
                       wb_valid && (wb_reg == RSEL'(r)) && (pend[r] != '0)})
                    2'b10:   pend[r] <= pend[r] + 1'b1;
                    2'b01:   pend[r] <= pend[r] - 1'b1;
                    default: ;
                endcase
            end
            if (underflow || sat_fire) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mr_rf_scoreboard.sv
// Scoreboard bench for mr_rf_scoreboard: a 3-port bypassing instance plus a
// 1-port non-bypassing instance share clock, reset, issue and writeback.
module tb_mr_rf_scoreboard;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int RSEL = 5;
    localparam int RD_PORTS = 3;
    localparam int PEND_BITS = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [RD_PORTS*RSEL-1:0] rd_sel;
    logic [RD_PORTS-1:0]      rd_use;
    logic [RD_PORTS*XLEN-1:0] rd_data;
    logic [RD_PORTS-1:0]      rd_hazard;
    logic                     hazard;
    logic                     issue_valid;
    logic [RSEL-1:0]          issue_dst;
    logic                     issue_ready;
    logic                     wb_valid;
    logic [RSEL-1:0]          wb_reg;
    logic [XLEN-1:0]          wb_val;
    logic                     busy;
    logic                     err;

    logic [XLEN-1:0] nb_data;
    logic [0:0]      nb_rd_hazard;
    logic            nb_hazard;
    logic            nb_ready;
    logic            nb_busy;
    logic            nb_err;

    mr_rf_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .RD_PORTS(RD_PORTS), .PEND_BITS(PEND_BITS), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_use(rd_use), .rd_data(rd_data),
        .rd_hazard(rd_hazard), .hazard(hazard), .issue_valid(issue_valid),
        .issue_dst(issue_dst), .issue_ready(issue_ready), .wb_valid(wb_valid),
        .wb_reg(wb_reg), .wb_val(wb_val), .busy(busy), .err(err)
    );

    mr_rf_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .RD_PORTS(1), .PEND_BITS(PEND_BITS), .BYPASS(0)
    ) dut_nb (
        .clk(clk), .rst(rst), .rd_sel(rd_sel[RSEL-1:0]), .rd_use(rd_use[0:0]),
        .rd_data(nb_data), .rd_hazard(nb_rd_hazard), .hazard(nb_hazard),
        .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_ready(nb_ready),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_val(wb_val), .busy(nb_busy), .err(nb_err)
    );

    initial forever #5 clk = ~clk;

    typedef enum {SIG_DATA0, SIG_DATA1, SIG_DATA2, SIG_HZV, SIG_HZ, SIG_READY,
                  SIG_BUSY, SIG_ERR, SIG_NB_DATA, SIG_NB_HZ, SIG_NB_ERR} sig_e;
    typedef struct {
        string       name;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    event sample_ev;

    task automatic expect_val(input string n, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sig  = s;
        e.exp  = v;
        q.push_back(e);
    endtask

    // Monitor: drains pending expectations at each falling edge, or on demand.
    always begin
        exp_t        e;
        logic [31:0] act;
        @(negedge clk or sample_ev);
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sig)
                SIG_DATA0:   act = rd_data[0 +: 32];
                SIG_DATA1:   act = rd_data[32 +: 32];
                SIG_DATA2:   act = rd_data[64 +: 32];
                SIG_HZV:     act = 32'(rd_hazard);
                SIG_HZ:      act = 32'(hazard);
                SIG_READY:   act = 32'(issue_ready);
                SIG_BUSY:    act = 32'(busy);
                SIG_ERR:     act = 32'(err);
                SIG_NB_DATA: act = nb_data;
                SIG_NB_HZ:   act = 32'(nb_hazard);
                SIG_NB_ERR:  act = 32'(nb_err);
                default:     act = 'x;
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        rd_use      = '0;
    endtask

    task automatic sel3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        rd_sel = {c, b, a};
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] v);
        wb_valid = 1'b1;
        wb_reg   = r;
        wb_val   = v;
    endtask

    task automatic issue(input logic [4:0] r);
        issue_valid = 1'b1;
        issue_dst   = r;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_dst = 5'd3;
        wb_valid = 1'b0;
        wb_reg = '0;
        wb_val = '0;
        rd_use = '0;
        sel3(5, 0, 5);

        // Reset state
        @(posedge clk); #1;
        expect_val("rst_rd0", SIG_DATA0, 0);
        expect_val("rst_rd1", SIG_DATA1, 0);
        expect_val("rst_hzv", SIG_HZV, 0);
        expect_val("rst_busy", SIG_BUSY, 0);
        expect_val("rst_err", SIG_ERR, 0);
        expect_val("rst_ready", SIG_READY, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        expect_val("post_rst_ready", SIG_READY, 1);

        // Unreserved writeback to x5
        step(); wb(5, 32'hDEADBEEF);
        expect_val("x5_bypass_rd0", SIG_DATA0, 32'hDEADBEEF);
        expect_val("x5_bypass_rd2", SIG_DATA2, 32'hDEADBEEF);
        expect_val("x0_rd1", SIG_DATA1, 0);
        expect_val("x5_err_same_cyc", SIG_ERR, 0);
        expect_val("nb_x5_same_cyc", SIG_NB_DATA, 0);
        step();
        expect_val("x5_err_next", SIG_ERR, 1);
        expect_val("x5_stored", SIG_DATA0, 32'hDEADBEEF);
        expect_val("nb_x5_stored", SIG_NB_DATA, 32'hDEADBEEF);
        expect_val("nb_x5_err", SIG_NB_ERR, 1);

        do_reset();
        expect_val("reset2_err", SIG_ERR, 0);

        // RAW hazard on x3 resolved by writeback
        step(); issue(3);
        expect_val("x3_ready", SIG_READY, 1);
        step(); sel3(3, 0, 0); rd_use = 3'b001;
        expect_val("x3_hz", SIG_HZ, 1);
        expect_val("x3_hzv", SIG_HZV, 3'b001);
        expect_val("x3_busy", SIG_BUSY, 1);
        expect_val("nb_x3_hz", SIG_NB_HZ, 1);
        step(); rd_use = 3'b001; wb(3, 32'h12345678);
        expect_val("x3_wb_hz", SIG_HZ, 0);
        expect_val("x3_wb_rd0", SIG_DATA0, 32'h12345678);
        expect_val("nb_x3_wb_hz", SIG_NB_HZ, 1);
        expect_val("nb_x3_wb_data", SIG_NB_DATA, 0);
        step(); rd_use = 3'b001;
        expect_val("nb_x3_next_hz", SIG_NB_HZ, 0);
        expect_val("nb_x3_next_data", SIG_NB_DATA, 32'h12345678);
        expect_val("x3_next_busy", SIG_BUSY, 0);
        expect_val("x3_next_err", SIG_ERR, 0);

        // Saturate x7
        step(); issue(7);
        step(); issue(7);
        step(); issue(7);
        expect_val("x7_ready_pend2", SIG_READY, 1);
        step(); issue_dst = 5'd7;
        expect_val("x7_sat_ready", SIG_READY, 0);
        expect_val("x7_sat_busy", SIG_BUSY, 1);
        step(); issue_dst = 5'd8;
        expect_val("x8_ready", SIG_READY, 1);
        step(); issue_dst = 5'd7; wb(7, 32'h1);
        expect_val("x7_wb_same_ready", SIG_READY, 0);
        step(); issue_dst = 5'd7; wb(7, 32'h2);
        expect_val("x7_ready_after_wb", SIG_READY, 1);
        step(); wb(7, 32'h3);
        expect_val("x7_busy_last", SIG_BUSY, 1);
        step(); sel3(7, 0, 0);
        expect_val("x7_drained_busy", SIG_BUSY, 0);
        expect_val("x7_err", SIG_ERR, 0);
        expect_val("x7_data", SIG_DATA0, 32'h3);

        // Same-cycle issue and writeback on x9
        step(); issue(9);
        step(); issue(9); wb(9, 32'h99); sel3(9, 0, 0);
        expect_val("x9_same_cyc_hzv", SIG_HZV, 0);
        step();
        expect_val("x9_hzv_held", SIG_HZV, 3'b001);
        expect_val("x9_err", SIG_ERR, 0);
        expect_val("x9_data", SIG_DATA0, 32'h99);
        step(); wb(9, 32'h9A);
        step();
        expect_val("x9_busy_done", SIG_BUSY, 0);
        expect_val("x9_err_done", SIG_ERR, 0);

        // Three ports on x0, x4, x4
        step(); issue(4);
        step(); sel3(0, 4, 4); rd_use = 3'b010;
        expect_val("p3_hzv", SIG_HZV, 3'b110);
        expect_val("p3_hz_used", SIG_HZ, 1);
        step(); rd_use = 3'b001;
        expect_val("p3_hz_unused", SIG_HZ, 0);
        expect_val("p3_hzv2", SIG_HZV, 3'b110);
        step(); wb(4, 32'h44);
        step();
        expect_val("p3_busy_done", SIG_BUSY, 0);

        // Asynchronous reset mid-cycle
        step(); issue(2);
        step(); issue(2); wb(6, 32'h66);
        step(); sel3(2, 0, 0); issue_dst = 5'd2;
        expect_val("pre_rst_busy", SIG_BUSY, 1);
        expect_val("pre_rst_err", SIG_ERR, 1);
        expect_val("pre_rst_hzv", SIG_HZV, 3'b001);
        expect_val("pre_rst_ready", SIG_READY, 1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        expect_val("async_busy", SIG_BUSY, 0);
        expect_val("async_err", SIG_ERR, 0);
        expect_val("async_ready", SIG_READY, 0);
        expect_val("async_hzv", SIG_HZV, 0);
        ->sample_ev;
        step();
        step(); rst = 1'b0;
        expect_val("after_rst_ready", SIG_READY, 1);
        expect_val("after_rst_busy", SIG_BUSY, 0);
        step();
        step();

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drained: %0d left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL watchdog: time limit reached, expected bench completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
